mem_arbiter: RTL

- Two-requester arbiter sharing one single-port synchronous word RAM (1-cycle read latency) inside z1top.
- Requester 0 is the CPU data port; requester 1 is the debug/firmware loader.
- Round-robin fairness, per-master request/grant handshake, in-order read response, out-of-range address error.
- Sits between the core/loader and the data-memory block instance.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous word RAM.
// Master 0 is the CPU data port and master 1 is the debug/firmware loader.
// Grants are combinational in IDLE. A read, or any out-of-range access, spends one
// RESP cycle returning rvalid to the master that was granted.

// Checks whether a word index falls inside the RAM.
module mem_arbiter_range #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic [ADDR_WIDTH-3:0] word_idx,
   output logic                  in_range
);
   assign in_range = ({2'b00, word_idx} < ADDR_WIDTH'(DEPTH_WORDS));
endmodule

module mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int MEM_AW      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_wstrb,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [31:0]           m0_rdata,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_wstrb,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [31:0]           m1_rdata,
   output logic                  m1_err,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);
   typedef enum logic {IDLE, RESP} state_t;

   state_t state_q, state_d;
   logic   last_grant_q, last_grant_d;
   logic   resp_m_q, resp_m_d;
   logic   err_pending_q, err_pending_d;

   // Per-master views so the selection logic can index by master number
   logic [1:0]                 req, we, in_range;
   logic [1:0][ADDR_WIDTH-1:0] addr;
   logic [1:0][31:0]           wdata, rdata;
   logic [1:0][3:0]            wstrb;
   logic [1:0]                 gnt, rvalid, err;
   logic                       sel;
   logic                       unused_addr_lsb;

   assign req   = {m1_req, m0_req};
   assign we    = {m1_we, m0_we};
   assign addr  = {m1_addr, m0_addr};
   assign wdata = {m1_wdata, m0_wdata};
   assign wstrb = {m1_wstrb, m0_wstrb};

   // Byte-offset bits are don't-care; the RAM is word addressed
   assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

   for (genvar i = 0; i < 2; i++) begin : g_port
      mem_arbiter_range #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .DEPTH_WORDS (DEPTH_WORDS)
      ) u_range (
         .word_idx (addr[i][ADDR_WIDTH-1:2]),
         .in_range (in_range[i])
      );
   end

   // Arbitration, RAM drive and response steering for the current state
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      resp_m_d      = resp_m_q;
      err_pending_d = err_pending_q;
      sel           = 1'b0;
      gnt           = '0;
      rvalid        = '0;
      rdata         = '0;
      err           = '0;
      mem_en        = 1'b0;
      mem_we        = '0;
      mem_addr      = '0;
      mem_wdata     = '0;
      case (state_q)
         IDLE: begin
            // No grant while reset is held, even though the state already reads IDLE
            if (!rst && (|req)) begin
               // When both masters request, the master that was not granted last wins
               sel          = (req[0] & req[1]) ? ~last_grant_q : req[1];
               gnt[sel]     = 1'b1;
               last_grant_d = sel;
               if (in_range[sel]) begin
                  mem_en    = 1'b1;
                  mem_addr  = addr[sel][MEM_AW+1:2];
                  mem_wdata = wdata[sel];
                  mem_we    = we[sel] ? wstrb[sel] : 4'b0000;
                  if (!we[sel]) begin
                     state_d       = RESP;
                     resp_m_d      = sel;
                     err_pending_d = 1'b0;
                  end
               end else begin
                  // Out-of-range accesses never reach the RAM but still get a response
                  state_d       = RESP;
                  resp_m_d      = sel;
                  err_pending_d = 1'b1;
               end
            end
         end
         RESP: begin
            rvalid[resp_m_q] = 1'b1;
            rdata[resp_m_q]  = err_pending_q ? 32'h0 : mem_rdata;
            err[resp_m_q]    = err_pending_q;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; last_grant resets to 1 so master 0 wins the first contested cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         resp_m_q      <= 1'b0;
         err_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         resp_m_q      <= resp_m_d;
         err_pending_q <= err_pending_d;
      end
   end

   assign m0_gnt    = gnt[0];
   assign m0_rvalid = rvalid[0];
   assign m0_rdata  = rdata[0];
   assign m0_err    = err[0];
   assign m1_gnt    = gnt[1];
   assign m1_rvalid = rvalid[1];
   assign m1_rdata  = rdata[1];
   assign m1_err    = err[1];
endmodule
